// File: rtl/gmsk_pkg.sv
// Shared GMSK definitions for the modulator and demodulator.
package gmsk_pkg;

    localparam int unsigned BITS_PER_SAMPLE    = 8;
    localparam int unsigned SAMPLES_PER_SYMBOL = 128;

    localparam int unsigned PROD_WIDTH  = 2 * BITS_PER_SAMPLE;
    localparam int unsigned DISC_WIDTH  = 2 * BITS_PER_SAMPLE + 1;
    localparam int unsigned PHASE_WIDTH = $clog2(SAMPLES_PER_SYMBOL);
    localparam int unsigned ACC_WIDTH   = DISC_WIDTH + PHASE_WIDTH;

    typedef logic signed [BITS_PER_SAMPLE-1:0] sample_t;
    typedef logic signed [PROD_WIDTH-1:0]      prod_t;
    typedef logic signed [DISC_WIDTH-1:0]      disc_t;
    typedef logic signed [ACC_WIDTH-1:0]       acc_t;
    typedef logic [PHASE_WIDTH-1:0]            phase_t;

    // Bit mapping: counter-clockwise (positive) rotation is a 1.
    localparam logic BIT_CCW = 1'b1;
    localparam logic BIT_CW  = 1'b0;

endpackage

// File: rtl/gmsk_rx_if.sv
// Sample-in / bit-out bus of the GMSK demodulator.
interface gmsk_rx_if;
    import gmsk_pkg::*;

    logic    clk_en;
    sample_t inphase_in;
    sample_t quadrature_in;
    logic    sample_strobe;
    logic    symbol_sync;
    logic    output_bit;
    logic    output_bit_strobe;
    disc_t   discriminator_out;

    modport master (
        output clk_en,
        output inphase_in,
        output quadrature_in,
        output sample_strobe,
        output symbol_sync,
        input  output_bit,
        input  output_bit_strobe,
        input  discriminator_out
    );

    modport slave (
        input  clk_en,
        input  inphase_in,
        input  quadrature_in,
        input  sample_strobe,
        input  symbol_sync,
        output output_bit,
        output output_bit_strobe,
        output discriminator_out
    );

endinterface

// File: rtl/gmsk_phase_discriminator.sv
// Stage 1: registered cross product of the previous and current I/Q samples.
module gmsk_phase_discriminator
    import gmsk_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    accept_i,
    input  sample_t inphase_i,
    input  sample_t quadrature_i,
    output disc_t   disc_o,
    output logic    valid_o
);

    sample_t prev_i_q, prev_q_q;
    logic    prev_valid_q;
    disc_t   disc_q, disc_d;
    logic    valid_q;
    prod_t   prod_a, prod_b;

    // Full-precision cross product; the first sample after reset has no predecessor.
    always_comb begin
        prod_a = PROD_WIDTH'(prev_i_q) * PROD_WIDTH'(quadrature_i);
        prod_b = PROD_WIDTH'(prev_q_q) * PROD_WIDTH'(inphase_i);
        disc_d = '0;
        if (prev_valid_q) begin
            disc_d = DISC_WIDTH'(prod_a) - DISC_WIDTH'(prod_b);
        end
    end

    // Sample history and discriminator register, advanced only on accepted samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_i_q     <= '0;
            prev_q_q     <= '0;
            prev_valid_q <= 1'b0;
            disc_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            valid_q <= accept_i;
            if (accept_i) begin
                prev_i_q     <= inphase_i;
                prev_q_q     <= quadrature_i;
                prev_valid_q <= 1'b1;
                disc_q       <= disc_d;
            end
        end
    end

    assign disc_o  = disc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/gmsk_rx.sv
// GMSK demodulator: discriminator, per-symbol integrate-and-dump, hard slicer.
module gmsk_rx
    import gmsk_pkg::*;
(
    input logic       clock,
    input logic       reset,
    gmsk_rx_if.slave  bus
);

    localparam phase_t LastPhase = phase_t'(SAMPLES_PER_SYMBOL - 1);

    logic   accept;
    disc_t  disc;
    logic   s1_valid;

    phase_t phase_q, phase_d;
    phase_t tag_q, tag_d, tag_cur;
    acc_t   acc_q, acc_d, sum;
    logic   bit_q, bit_d;
    logic   strobe_q, strobe_d;

    assign accept = bus.sample_strobe & bus.clk_en;

    gmsk_phase_discriminator u_disc (
        .clock        (clock),
        .reset        (reset),
        .accept_i     (accept),
        .inphase_i    (bus.inphase_in),
        .quadrature_i (bus.quadrature_in),
        .disc_o       (disc),
        .valid_o      (s1_valid)
    );

    // Phase tagging: sync forces phase 0, counter wraps naturally at the power of two.
    always_comb begin
        tag_cur = bus.symbol_sync ? '0 : phase_q;
        tag_d   = tag_q;
        phase_d = phase_q;
        if (accept) begin
            tag_d   = tag_cur;
            phase_d = tag_cur + phase_t'(1);
        end
    end

    // Stage 2: load on phase 0, accumulate mid-symbol, slice on the last phase.
    always_comb begin
        acc_d    = acc_q;
        bit_d    = bit_q;
        strobe_d = 1'b0;
        sum      = acc_q + ACC_WIDTH'(disc);
        if (s1_valid) begin
            if (tag_q == '0) begin
                acc_d = ACC_WIDTH'(disc);
            end else if (tag_q == LastPhase) begin
                // A zero sum slices to the clockwise symbol.
                bit_d    = (sum > acc_t'(0)) ? BIT_CCW : BIT_CW;
                strobe_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

    // State registers for tagging and integration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q  <= '0;
            tag_q    <= '0;
            acc_q    <= '0;
            bit_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            tag_q    <= tag_d;
            acc_q    <= acc_d;
            bit_q    <= bit_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.output_bit        = bit_q;
    assign bus.output_bit_strobe = strobe_q;
    assign bus.discriminator_out = disc;

endmodule
